// File: rtl/shiftreg_rw_pkg.sv
// Shared definitions for the shift-register read/write controller.
// Holds the FSM state encoding, a constant clog2 helper and the DIV legality check.
package shiftreg_rw_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Ceiling log2, floored at 1 so that a counter never collapses to zero width.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned v;
      result = 0;
      v      = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      if (result == 0) result = 1;
      return result;
   endfunction

   // The serial clock needs two equal halves, so DIV must be even and at least 2.
   function automatic bit div_ok(input int unsigned div);
      return (div >= 2) && ((div % 2) == 0);
   endfunction

endpackage

// File: rtl/sr_bit_timer.sv
// Serial bit timer: div_cnt paces one serial bit over DIV clk cycles and
// bit_cnt counts bits within the word.
// Ports:
//   clk, rst      : clock, async active-low reset
//   load          : accepted start; restarts both counters at zero
//   shift_en      : FSM is in SHIFT (counts div and bits, generates sr_clk)
//   latch_en      : FSM is in LATCH (counts div only, sr_clk held low)
//   sr_clk        : serial clock, high while div_cnt >= DIV/2 in SHIFT
//   phase_launch  : current cycle has div_cnt == 0
//   phase_sample  : current cycle has div_cnt == DIV/2 (sr_clk rising cycle)
//   phase_wrap    : current cycle has div_cnt == DIV-1
//   last_bit      : current bit is bit WIDTH-1
// All outputs are registers whose value describes the current cycle's counters.
module sr_bit_timer
   import shiftreg_rw_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic shift_en,
   input  logic latch_en,
   output logic sr_clk,
   output logic phase_launch,
   output logic phase_sample,
   output logic phase_wrap,
   output logic last_bit
);

   localparam int unsigned DIV_W = clog2(DIV);
   localparam int unsigned BIT_W = clog2(WIDTH + 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_next;
   logic [BIT_W-1:0] bit_cnt;
   logic [BIT_W-1:0] bit_next;
   logic             sr_clk_next;

   // Next counter values; both counters rest at zero outside SHIFT/LATCH.
   always_comb begin
      div_next    = '0;
      bit_next    = '0;
      sr_clk_next = 1'b0;
      if (!load && (shift_en || latch_en)) begin
         div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
         bit_next = bit_cnt;
         if (shift_en && (div_cnt == DIV_LAST)) begin
            bit_next = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
         end
      end
      // Leaving SHIFT after the last bit wraps div_next to 0, so sr_clk lands low.
      sr_clk_next = shift_en && !load && (div_next >= DIV_HALF);
   end

   // Counters plus phase flags decoded one cycle early so they are registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt      <= '0;
         bit_cnt      <= '0;
         sr_clk       <= 1'b0;
         phase_launch <= 1'b1;
         phase_sample <= 1'b0;
         phase_wrap   <= 1'b0;
         last_bit     <= (WIDTH == 1);
      end else begin
         div_cnt      <= div_next;
         bit_cnt      <= bit_next;
         sr_clk       <= sr_clk_next;
         phase_launch <= (div_next == '0);
         phase_sample <= (div_next == DIV_HALF);
         phase_wrap   <= (div_next == DIV_LAST);
         last_bit     <= (bit_next == BIT_LAST);
      end
   end

endmodule

// File: rtl/shiftreg_rw_ctrl.sv
// Shift-register read/write controller. On each accepted start it shifts
// data_in MSB-first into an external chain on sr_din/sr_clk, captures the
// word returned on sr_dout, strobes sr_load for DIV cycles and pulses done.
// Ports:
//   clk, rst   : clock, async active-low reset
//   start      : one-cycle start pulse (already in the clk domain)
//   data_in    : word to write, sampled on an accepted start
//   sr_dout    : serial data returned from the chain
//   sr_clk     : serial shift clock (clk/DIV)
//   sr_din     : serial data to the chain, MSB first
//   sr_load    : latch strobe to the chain
//   data_out   : captured readback word, held until the next done
//   busy       : high from the cycle after an accepted start through DONE
//   done       : one-cycle pulse, data_out valid in the same cycle
//   overrun    : flags a start that arrives while not idle
module shiftreg_rw_ctrl
   import shiftreg_rw_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   input  logic             sr_dout,
   output logic             sr_clk,
   output logic             sr_din,
   output logic             sr_load,
   output logic [WIDTH-1:0] data_out,
   output logic             busy,
   output logic             done,
   output logic             overrun
);

   // Reject illegal parameterisations at elaboration.
   if (!div_ok(DIV)) begin : g_bad_div
      $error("shiftreg_rw_ctrl: DIV must be even and >= 2");
   end
   if (WIDTH < 1) begin : g_bad_width
      $error("shiftreg_rw_ctrl: WIDTH must be >= 1");
   end

   state_e           state;
   state_e           state_d;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_d;
   logic [WIDTH-1:0] cap;
   logic [WIDTH-1:0] cap_d;
   logic [WIDTH-1:0] data_out_d;
   logic             sr_din_d;
   logic             sr_load_d;
   logic             busy_d;
   logic             done_d;
   logic             accept_c;
   logic             phase_launch;
   logic             phase_sample;
   logic             phase_wrap;
   logic             last_bit;

   assign accept_c = start && (state == IDLE);
   // Combinational so the flag lines up with the offending start cycle itself.
   assign overrun  = start && (state != IDLE);

   sr_bit_timer #(
      .WIDTH (WIDTH),
      .DIV   (DIV)
   ) u_timer (
      .clk          (clk),
      .rst          (rst),
      .load         (accept_c),
      .shift_en     (state == SHIFT),
      .latch_en     (state == LATCH),
      .sr_clk       (sr_clk),
      .phase_launch (phase_launch),
      .phase_sample (phase_sample),
      .phase_wrap   (phase_wrap),
      .last_bit     (last_bit)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state;
      shreg_d    = shreg;
      cap_d      = cap;
      data_out_d = data_out;
      sr_din_d   = sr_din;
      sr_load_d  = 1'b0;
      done_d     = 1'b0;
      busy_d     = 1'b0;

      unique case (state)
         IDLE: begin
            if (accept_c) begin
               state_d  = SHIFT;
               shreg_d  = data_in;
               cap_d    = '0;
               sr_din_d = data_in[WIDTH-1];
            end
         end
         SHIFT: begin
            // Pre-advance after launch so shreg MSB is already the next bit at wrap.
            if (phase_launch) shreg_d = shreg << 1;
            if (phase_sample) cap_d = (cap << 1) | WIDTH'(sr_dout);
            if (phase_wrap) begin
               if (last_bit) begin
                  state_d   = LATCH;
                  sr_din_d  = 1'b0;
                  sr_load_d = 1'b1;
               end else begin
                  sr_din_d = shreg[WIDTH-1];
               end
            end
         end
         LATCH: begin
            sr_load_d = 1'b1;
            if (phase_wrap) begin
               state_d    = DONE;
               sr_load_d  = 1'b0;
               done_d     = 1'b1;
               data_out_d = cap;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         shreg    <= '0;
         cap      <= '0;
         data_out <= '0;
         sr_din   <= 1'b0;
         sr_load  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_d;
         shreg    <= shreg_d;
         cap      <= cap_d;
         data_out <= data_out_d;
         sr_din   <= sr_din_d;
         sr_load  <= sr_load_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

endmodule

// File: tb/tb_shiftreg_rw_ctrl.sv
// Self-checking bench for shiftreg_rw_ctrl (WIDTH=8, DIV=4) with a behavioural
// 8-bit serial chain that can be looped back onto sr_dout.
module tb_shiftreg_rw_ctrl;

   localparam int unsigned W       = 8;
   localparam int unsigned D       = 4;
   localparam int          EXP_LAT = 1 + (W + 1) * D;
   localparam int          BUDGET  = 80;

   localparam logic [1:0] M_TIE0 = 2'd0;
   localparam logic [1:0] M_TIE1 = 2'd1;
   localparam logic [1:0] M_LOOP = 2'd2;

   logic         clk     = 1'b0;
   logic         rst     = 1'b0;
   logic         start   = 1'b0;
   logic [W-1:0] data_in = '0;
   logic         sr_dout;
   logic         sr_clk;
   logic         sr_din;
   logic         sr_load;
   logic [W-1:0] data_out;
   logic         busy;
   logic         done;
   logic         overrun;

   logic [1:0]   dmode   = M_LOOP;
   logic [7:0]   chain   = 8'h00;
   logic         out_bit = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   // Per-transaction observations.
   logic [7:0] r_got;
   logic [7:0] r_seq;
   int         r_lat, r_nclk, r_nload, r_busy_err, r_ovr_cnt, r_ovr_k, r_done_cnt;

   typedef struct {
      logic [7:0] data;
      logic [1:0] mode;
      logic [7:0] exp_rd;
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   shiftreg_rw_ctrl #(.WIDTH(W), .DIV(D)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .data_in  (data_in),
      .sr_dout  (sr_dout),
      .sr_clk   (sr_clk),
      .sr_din   (sr_din),
      .sr_load  (sr_load),
      .data_out (data_out),
      .busy     (busy),
      .done     (done),
      .overrun  (overrun)
   );

   // External chain: shifts sr_din in on sr_clk rise; sr_dout presents the bit just pushed out.
   always @(posedge sr_clk) begin
      out_bit <= chain[7];
      chain   <= {chain[6:0], sr_din};
   end
   assign sr_dout = (dmode == M_LOOP) ? out_bit : (dmode == M_TIE1);

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Entered just after a clock edge; start is high for the cycle t0 that follows.
   task automatic run_txn(input logic [7:0] d, input int extra_k);
      logic prev;
      start   = 1'b1;
      data_in = d;
      @(posedge clk); #1;
      start = 1'b0;
      r_lat = -1; r_nclk = 0; r_nload = 0; r_seq = '0; r_got = '0;
      r_busy_err = 0; r_ovr_cnt = 0; r_ovr_k = -1; r_done_cnt = 0;
      prev = 1'b0;
      for (int k = 1; k <= BUDGET; k++) begin
         if (k == extra_k) begin
            start   = 1'b1;
            data_in = ~d;
         end
         #1;
         if (overrun) begin r_ovr_cnt++; r_ovr_k = k; end
         if (sr_clk && !prev) begin r_nclk++; r_seq = {r_seq[6:0], sr_din}; end
         prev = sr_clk;
         if (sr_load) r_nload++;
         if (r_lat < 0) begin
            if (!busy) r_busy_err++;
         end else begin
            if (busy) r_busy_err++;
            start = 1'b0;
            break;
         end
         if (done) begin r_done_cnt++; r_lat = k; r_got = data_out; end
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   task automatic do_txn(input string name, input logic [7:0] d, input logic [1:0] mode,
                         input logic [7:0] exp_rd, input int extra_k);
      dmode = mode;
      run_txn(d, extra_k);
      check({name, " data_out"}, int'(r_got), int'(exp_rd));
      check({name, " done latency"}, r_lat, EXP_LAT);
      check({name, " done count"}, r_done_cnt, 1);
      check({name, " sr_clk rises"}, r_nclk, int'(W));
      check({name, " sr_load cycles"}, r_nload, int'(D));
      check({name, " sr_din bits"}, int'(r_seq), int'(d));
      check({name, " busy window errs"}, r_busy_err, 0);
      check({name, " overrun pulses"}, r_ovr_cnt, (extra_k > 0) ? 1 : 0);
      if (extra_k > 0) check({name, " overrun cycle"}, r_ovr_k, extra_k);
   endtask

   initial begin
      logic [7:0] last_wr;
      logic [7:0] d;
      logic       seen_done;

      vecs[0] = '{data: 8'hA5, mode: M_LOOP, exp_rd: 8'h00};
      vecs[1] = '{data: 8'h3C, mode: M_LOOP, exp_rd: 8'hA5};
      vecs[2] = '{data: 8'h81, mode: M_TIE1, exp_rd: 8'hFF};
      vecs[3] = '{data: 8'h7E, mode: M_LOOP, exp_rd: 8'h81};
      vecs[4] = '{data: 8'h00, mode: M_TIE0, exp_rd: 8'h00};
      vecs[5] = '{data: 8'hFF, mode: M_LOOP, exp_rd: 8'h00};
      vecs[6] = '{data: 8'hA5, mode: M_TIE0, exp_rd: 8'h00};
      vecs[7] = '{data: 8'h5A, mode: M_LOOP, exp_rd: 8'hA5};

      // Reset held for 50 ns with start toggling.
      seen_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         start = ~start;
         data_in = 8'hC3;
         #1;
         if (done) seen_done = 1'b1;
      end
      start = 1'b1;
      #1;
      check("reset sr_clk", int'(sr_clk), 0);
      check("reset sr_din", int'(sr_din), 0);
      check("reset sr_load", int'(sr_load), 0);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset overrun", int'(overrun), 0);
      check("reset data_out", int'(data_out), 0);
      check("reset no done seen", int'(seen_done), 0);
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("post-reset busy", int'(busy), 0);
      check("post-reset done", int'(done), 0);

      // Directed vector table, back-to-back starts in the first idle cycle.
      for (int i = 0; i < 8; i++) begin
         do_txn($sformatf("vec%0d", i), vecs[i].data, vecs[i].mode, vecs[i].exp_rd, 0);
      end
      last_wr = vecs[7].data;

      // Random loopback traffic: the chain always returns the previous word.
      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom);
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         do_txn($sformatf("rand%0d", i), d, M_LOOP, last_wr, 0);
         last_wr = d;
      end

      // Start at t0+10 is rejected; its changed data_in must not be written.
      @(posedge clk); #1;
      do_txn("overrun mid", 8'h96, M_LOOP, last_wr, 10);
      last_wr = 8'h96;
      // Start in the DONE cycle is an overrun; start one cycle later is accepted.
      do_txn("overrun done", 8'h4B, M_LOOP, last_wr, EXP_LAT);
      last_wr = 8'h4B;
      do_txn("idle after done", 8'hE1, M_LOOP, last_wr, 0);

      // Reset in the middle of SHIFT (sr_clk high phase at t0+15).
      @(posedge clk); #1;
      start   = 1'b1;
      data_in = 8'hC3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) begin @(posedge clk); #1; end
      check("mid sr_clk before reset", int'(sr_clk), 1);
      rst = 1'b0;
      #1;
      check("mid-reset sr_clk", int'(sr_clk), 0);
      check("mid-reset sr_load", int'(sr_load), 0);
      check("mid-reset busy", int'(busy), 0);
      check("mid-reset data_out", int'(data_out), 0);
      seen_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (done || busy || sr_din) seen_done = 1'b1;
      end
      check("mid-reset quiet", int'(seen_done), 0);
      rst = 1'b1;
      @(posedge clk); #1;
      do_txn("after mid reset", 8'h69, M_TIE1, 8'hFF, 0);
      do_txn("after mid reset loop", 8'h12, M_LOOP, 8'h69, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
